// File: rtl/isp1761_bus_sequencer.sv
// isp1761_bus_sequencer
// Turns single-word Avalon-MM reads/writes into timed ISP1761 bus cycles:
// address setup, strobe, write hold and inter-access recovery. The master is
// stalled with avs_waitrequest until the one-cycle DONE state.
// Optional build macro: ISP1761_IRQ_SYNC_EN. When it is defined, isp_irq goes
// through a two-flop synchronizer. When it is undefined, isp_irq feeds
// avs_irq directly.
module isp1761_bus_sequencer #(
    parameter int unsigned SETUP_CYC    = 1,  // 1..15
    parameter int unsigned STROBE_CYC   = 3,  // 1..15
    parameter int unsigned HOLD_CYC     = 1,  // 0..15
    parameter int unsigned RECOVERY_CYC = 4   // 0..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        avs_irq,
    output logic        isp_cs_n,
    output logic        isp_rd_n,
    output logic        isp_wr_n,
    output logic [17:0] isp_address,
    output logic [31:0] isp_writedata,
    input  logic [31:0] isp_readdata,
    input  logic        isp_irq,
    output logic        isp_reset_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_RECOVER
    } state_e;

    // The phase counter is loaded with N-1, so a phase lasts N cycles.
    // Zero-length phases are skipped, so their reload values are never used.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
    localparam logic [3:0] REC_LD    = 4'((RECOVERY_CYC == 0) ? 0 : RECOVERY_CYC - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        is_rd_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        cs_n_q, rd_n_q, wr_n_q, wait_q, isp_rst_q;

    // Main sequencer. Strobes and waitrequest are registered and change on the
    // same edge as the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            is_rd_q <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            wait_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A read wins when both requests are present.
                    if (avs_read || avs_write) begin
                        addr_q  <= avs_address;
                        wdata_q <= avs_writedata;
                        is_rd_q <= avs_read;
                        cnt_q   <= SETUP_LD;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        cnt_q   <= STROBE_LD;
                        state_q <= S_STROBE;
                        cs_n_q  <= 1'b0;
                        if (is_rd_q) rd_n_q <= 1'b0;
                        else         wr_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        if (is_rd_q) begin
                            // Data is sampled in the last strobe cycle. cs_n and
                            // rd_n rise together so the bridge releases the bus
                            // cleanly.
                            rdata_q <= isp_readdata;
                            cs_n_q  <= 1'b1;
                            rd_n_q  <= 1'b1;
                            wait_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            wr_n_q <= 1'b1;
                            if (HOLD_CYC == 0) begin
                                cs_n_q  <= 1'b1;
                                wait_q  <= 1'b0;
                                state_q <= S_DONE;
                            end else begin
                                cnt_q   <= HOLD_LD;
                                state_q <= S_HOLD;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 4'd0) begin
                        cs_n_q  <= 1'b1;
                        wait_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    wait_q <= 1'b1;
                    if (RECOVERY_CYC == 0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= REC_LD;
                        state_q <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    // A request is not accepted here. It is picked up in IDLE.
                    if (cnt_q == 4'd0) state_q <= S_IDLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Controller reset: held low during reset, high one edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) isp_rst_q <= 1'b0;
        else          isp_rst_q <= 1'b1;
    end

`ifdef ISP1761_IRQ_SYNC_EN
    logic [1:0] irq_sync_q;

    // Two-flop synchronizer for the asynchronous controller interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_sync_q <= 2'b00;
        else          irq_sync_q <= {irq_sync_q[0], isp_irq};
    end

    assign avs_irq = irq_sync_q[1];
`else
    assign avs_irq = isp_irq;
`endif

    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = wait_q;
    assign isp_cs_n        = cs_n_q;
    assign isp_rd_n        = rd_n_q;
    assign isp_wr_n        = wr_n_q;
    assign isp_address     = {addr_q, 2'b00};
    assign isp_writedata   = wdata_q;
    assign isp_reset_n     = isp_rst_q;

endmodule

// File: tb/tb_isp1761_bus_sequencer.sv
// Testbench for isp1761_bus_sequencer. The reference model predicts each
// access from the timing rules: start = max(request, FSM free), latency,
// strobe widths, address/data stability and recovery spacing.
module tb_isp1761_bus_sequencer;

    localparam int SETUP  = 1;
    localparam int STROBE = 3;
    localparam int HOLD   = 1;
    localparam int RECOV  = 4;
`ifdef ISP1761_IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata, avs_readdata;
    logic        avs_waitrequest, avs_irq;
    logic        isp_cs_n, isp_rd_n, isp_wr_n;
    logic [17:0] isp_address;
    logic [31:0] isp_writedata, isp_readdata;
    logic        isp_irq, isp_reset_n;
    logic [31:0] bridge_data;

    int checks = 0, errors = 0, cyc = 0;
    int free_at = 0, prev_rise = -1, lat, n, k, g;
    logic [31:0] last_rdata = 32'd0;

    isp1761_bus_sequencer #(
        .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD), .RECOVERY_CYC(RECOV)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .avs_irq(avs_irq),
        .isp_cs_n(isp_cs_n), .isp_rd_n(isp_rd_n), .isp_wr_n(isp_wr_n),
        .isp_address(isp_address), .isp_writedata(isp_writedata),
        .isp_readdata(isp_readdata), .isp_irq(isp_irq), .isp_reset_n(isp_reset_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The bridge drives valid data only while the read strobe is low.
    always_comb isp_readdata = !isp_rd_n ? bridge_data : ~bridge_data;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at posedge+1. Returns at posedge+1 after the completing edge.
    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        if (cycles > 0) #1;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, output int latency);
        int present, start, cnt, cs_cnt, rd_cnt, wr_cnt, cs_first, cs_last, done_cyc, body;
        bit done, addr_ok, wd_ok, is_rd;
        is_rd = rd;
        body  = SETUP + STROBE + (is_rd ? 0 : HOLD);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd; bridge_data = rdat;
        present = cyc;
        start   = (present > free_at) ? present : free_at;
        cnt = 0; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; cs_first = -1; cs_last = -1; done_cyc = -1;
        done = 0; addr_ok = 1; wd_ok = 1;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (!isp_cs_n) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = cyc;
                cs_last = cyc;
            end
            if (!isp_rd_n) rd_cnt++;
            if (!isp_wr_n) wr_cnt++;
            if (cyc > start) begin
                if (isp_address !== {a, 2'b00}) addr_ok = 0;
                if (!is_rd && isp_writedata !== wd) wd_ok = 0;
            end
            if (!avs_waitrequest) begin
                done = 1;
                done_cyc = cyc;
            end
        end
        latency = done_cyc - present;
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", latency, start + 1 + body - present);
        chk("cs_low_cycles", cs_cnt, STROBE + (is_rd ? 0 : HOLD));
        chk("rd_low_cycles", rd_cnt, is_rd ? STROBE : 0);
        chk("wr_low_cycles", wr_cnt, is_rd ? 0 : STROBE);
        chk("cs_fall_cycle", cs_first, start + 1 + SETUP);
        chk("addr_stable", 32'(addr_ok), 32'd1);
        if (!is_rd) chk("wdata_stable", 32'(wd_ok), 32'd1);
        if (is_rd) begin
            chk("rdata", avs_readdata, rdat);
            last_rdata = rdat;
        end else begin
            chk("rdata_held", avs_readdata, last_rdata);
        end
        if (prev_rise >= 0)
            chk("strobe_spacing", 32'(cs_first - prev_rise >= RECOV + SETUP + 2), 32'd1);
        prev_rise = cs_last + 1;
        free_at   = done_cyc + RECOV + 1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; avs_read = 1'b0; avs_write = 1'b0; avs_address = 16'd0;
        avs_writedata = 32'd0; isp_irq = 1'b0; bridge_data = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_cs_n", 32'(isp_cs_n), 32'd1);
        chk("rst_rd_n", 32'(isp_rd_n), 32'd1);
        chk("rst_wr_n", 32'(isp_wr_n), 32'd1);
        chk("rst_addr", 32'(isp_address), 32'd0);
        chk("rst_wdata", isp_writedata, 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_isp_reset_n", 32'(isp_reset_n), 32'd0);
        chk("rst_irq", 32'(avs_irq), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        free_at = cyc;
        @(negedge clk); chk("isp_reset_n_pre_edge", 32'(isp_reset_n), 32'd0);
        @(negedge clk); chk("isp_reset_n_post_edge", 32'(isp_reset_n), 32'd1);
        @(posedge clk); #1;

        // Directed read and write with defaults.
        access(1'b1, 1'b0, 16'h0040, 32'h0, 32'hDEADBEEF, lat);
        chk("read_latency_5", lat, 5);
        idle(8);
        access(1'b0, 1'b1, 16'h0041, 32'h12345678, 32'h0BAD0BAD, lat);
        chk("write_latency_6", lat, 6);
        idle(8);

        // Back-to-back write then read. The master holds each request.
        access(1'b0, 1'b1, 16'h0100, 32'hA5A5_5A5A, 32'h0, lat);
        access(1'b1, 1'b0, 16'h0101, 32'h0, 32'hCAFEF00D, lat);
        idle(8);

        // Both requests high: a read with no write strobe.
        access(1'b1, 1'b1, 16'h0222, 32'hFFFF_0000, 32'h1357_9BDF, lat);
        idle(8);

        // Randomized mix of reads, writes and both, with random idle gaps.
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, 2));
            g = int'($urandom_range(0, 4));
            idle(g);
            access(k != 1, k != 0, 16'($urandom), $urandom, $urandom, lat);
        end
        idle(8);

        // Reset asserted during the strobe phase of a read.
        avs_read = 1'b1; avs_address = 16'h1234; bridge_data = 32'h7777_8888;
        n = 0;
        while (isp_rd_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_strobe", 32'(isp_rd_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(isp_cs_n), 32'd1);
        chk("midrst_rd_n", 32'(isp_rd_n), 32'd1);
        chk("midrst_wr_n", 32'(isp_wr_n), 32'd1);
        chk("midrst_isp_reset_n", 32'(isp_reset_n), 32'd0);
        chk("midrst_wait", 32'(avs_waitrequest), 32'd1);
        avs_read = 1'b0;
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
        free_at = cyc; prev_rise = -1; last_rdata = 32'd0;
        @(negedge clk);
        chk("midrst_no_done", 32'(avs_waitrequest), 32'd1);
        chk("midrst_rdata_cleared", avs_readdata, 32'd0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h4321, 32'h0, 32'h2468_ACE0, lat);
        access(1'b0, 1'b1, 16'h4322, 32'h1122_3344, 32'h0, lat);

        // IRQ path.
        isp_irq = 1'b1;
        @(negedge clk); chk("irq_rise_c0", 32'(avs_irq), SYNC ? 32'd0 : 32'd1);
        @(negedge clk); chk("irq_rise_c1", 32'(avs_irq), SYNC ? 32'd0 : 32'd1);
        @(negedge clk); chk("irq_rise_c2", 32'(avs_irq), 32'd1);
        @(posedge clk); #1 isp_irq = 1'b0;
        @(negedge clk); chk("irq_fall_c0", 32'(avs_irq), SYNC ? 32'd1 : 32'd0);
        @(negedge clk); chk("irq_fall_c1", 32'(avs_irq), SYNC ? 32'd1 : 32'd0);
        @(negedge clk); chk("irq_fall_c2", 32'(avs_irq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
